// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: field slices, FSM states and halt encoding.
package inst_fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned WORD_W     = 16;

    localparam int unsigned OP1_MSB    = 15;
    localparam int unsigned OP1_LSB    = 14;
    localparam int unsigned RS_MSB     = 13;
    localparam int unsigned RS_LSB     = 11;
    localparam int unsigned RD_MSB     = 10;
    localparam int unsigned RD_LSB     = 8;
    localparam int unsigned OP3_MSB    = 7;
    localparam int unsigned OP3_LSB    = 4;
    localparam int unsigned DB_MSB     = 3;
    localparam int unsigned DB_LSB     = 0;

    localparam logic [1:0] HLT_OP1 = 2'b11;
    localparam logic [3:0] HLT_OP3 = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_e;

    function automatic logic is_halt_word(input logic [WORD_W-1:0] w);
        return (w[OP1_MSB:OP1_LSB] == HLT_OP1) && (w[OP3_MSB:OP3_LSB] == HLT_OP3);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Prefetch FIFO of {pc, word} entries; clear wins over push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, one-outstanding imem handshake, prefetch FIFO and IR field split.
// Optional halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned        DEPTH    = 2,
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [1:0]        op1_out,
    output logic [2:0]        Rs_Ra_op2_out,
    output logic [2:0]        Rd_Rb_cond_out,
    output logic [3:0]        op3_dFront_out,
    output logic [3:0]        dBack_out,
    output logic              halted
);

    localparam int unsigned    PTR_W     = $clog2(DEPTH);
    localparam int unsigned    ENTRY_W   = ADDR_W + WORD_W;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              halted_q, halted_d;

    logic              push, pop, clear, empty;
    logic              redir, halt_now, stop;
    logic [PTR_W:0]    count;
    logic [ENTRY_W-1:0] head;
    logic [WORD_W-1:0] head_word, out_word;
    logic [ADDR_W-1:0] head_pc;

    assign head_word = head[WORD_W-1:0];
    assign head_pc   = head[ENTRY_W-1:WORD_W];

`ifdef FETCH_HALT_DETECT_EN
    assign redir    = redirect & ~halted_q;
    assign halt_now = pop & is_halt_word(head_word);
`else
    assign redir    = redirect;
    assign halt_now = 1'b0;
`endif

    assign inst_valid = ~empty & ~halted_q;
    assign pop        = inst_valid & ~stall & ~redir;
    assign clear      = redir | halt_now;
    assign stop       = halted_q | halt_now;

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .wdata_i ({fetch_pc_q, imem_rdata}),
        .rdata_o (head),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            halted_q   <= halted_d;
        end
    end

    // A halt in flight behaves like a redirect that never loads a new PC.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        halted_d   = halted_q | halt_now;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redir && !stop && (count < DEPTH_CNT)) begin
                    addr_d  = fetch_pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_d = IDLE;
                    if (!redir && !stop) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 1'b1;
                    end
                end else if (redir || stop) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redir) begin
            fetch_pc_d = redirect_pc;
        end
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;
    assign halted    = halted_q;

    assign out_word       = inst_valid ? head_word : '0;
    assign inst_pc        = inst_valid ? head_pc : '0;
    assign op1_out        = out_word[OP1_MSB:OP1_LSB];
    assign Rs_Ra_op2_out  = out_word[RS_MSB:RS_LSB];
    assign Rd_Rb_cond_out = out_word[RD_MSB:RD_LSB];
    assign op3_dFront_out = out_word[OP3_MSB:OP3_LSB];
    assign dBack_out      = out_word[DB_MSB:DB_LSB];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit against a queue-based transaction model.
module tb_inst_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned ADDR_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic [1:0]  op1_out;
    logic [2:0]  Rs_Ra_op2_out;
    logic [2:0]  Rd_Rb_cond_out;
    logic [3:0]  op3_dFront_out;
    logic [3:0]  dBack_out;
    logic        halted;

    always #5 clock = ~clock;

    inst_fetch_unit #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .op1_out        (op1_out),
        .Rs_Ra_op2_out  (Rs_Ra_op2_out),
        .Rd_Rb_cond_out (Rd_Rb_cond_out),
        .op3_dFront_out (op3_dFront_out),
        .dBack_out      (dBack_out),
        .halted         (halted)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
    } entry_t;

    entry_t      mq[$];
    logic [15:0] m_fetch_pc;
    logic [15:0] m_req_addr;
    bit          m_busy;
    bit          m_discard;
    bit          m_halted;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch_pc = RESET_PC;
        m_req_addr = RESET_PC;
        m_busy     = 1'b0;
        m_discard  = 1'b0;
        m_halted   = 1'b0;
    endtask

    // One clock of the transaction-level model, using inputs as seen at the edge.
    task automatic model_step(input bit s, input bit r, input logic [15:0] rpc,
                              input bit a, input logic [15:0] rd);
        bit er, pop, hn, room;
        er   = r && !m_halted;
        room = mq.size() < DEPTH;
        pop  = (mq.size() > 0) && !s && !er;
        hn   = HALT_EN && pop && (mq[0].word[15:14] == 2'b11) && (mq[0].word[7:4] == 4'hF);
        if (er || hn) mq.delete();
        else if (pop) void'(mq.pop_front());
        if (m_busy && a) begin
            if (!m_discard && !er && !hn && !m_halted) begin
                mq.push_back('{m_fetch_pc, rd});
                m_fetch_pc = m_fetch_pc + 16'd1;
            end
            m_busy    = 1'b0;
            m_discard = 1'b0;
        end else if (m_busy) begin
            if (er || hn) m_discard = 1'b1;
        end else if (!er && !hn && !m_halted && room) begin
            m_busy     = 1'b1;
            m_req_addr = m_fetch_pc;
        end
        if (er) m_fetch_pc = rpc;
        if (hn) m_halted = 1'b1;
    endtask

    task automatic compare_all();
        bit          v;
        logic [15:0] w, p;
        v = mq.size() > 0;
        w = v ? mq[0].word : 16'h0000;
        p = v ? mq[0].pc : 16'h0000;
        check("inst_valid", inst_valid, v);
        check("inst_pc", inst_pc, p);
        check("op1", op1_out, w[15:14]);
        check("rs_ra_op2", Rs_Ra_op2_out, w[13:11]);
        check("rd_rb_cond", Rd_Rb_cond_out, w[10:8]);
        check("op3_dfront", op3_dFront_out, w[7:4]);
        check("dback", dBack_out, w[3:0]);
        check("imem_req", imem_req, m_busy);
        check("imem_addr", imem_addr, m_req_addr);
        check("halted", halted, m_halted);
    endtask

    // Called at a falling edge: check, drive, advance model, wait one cycle.
    task automatic step(input bit s, input bit r, input logic [15:0] rpc,
                        input int unsigned ack_pct, input int unsigned rmode);
        bit          a;
        logic [15:0] rd;
        compare_all();
        a = m_busy ? ($urandom_range(99) < ack_pct) : ($urandom_range(99) < 5);
        case (rmode)
            0: rd = m_req_addr ^ 16'hA500;
            1: begin
                rd = 16'($urandom);
                if (rd[15:14] == 2'b11 && rd[7:4] == 4'hF) rd[4] = 1'b0;
            end
            default: rd = 16'hC0F0;
        endcase
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_ack    = a;
        imem_rdata  = rd;
        model_step(s, r, rpc, a, rd);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        bit seen_req, seen_val, fdone;
        int n;

        do_reset();

        // sequential fetch, ack one cycle after each request
        fdone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!fdone && mq.size() > 0 && mq[0].pc == 16'h0001) begin
                check("a501_op1", op1_out, 2);
                check("a501_rs", Rs_Ra_op2_out, 4);
                check("a501_rd", Rd_Rb_cond_out, 5);
                check("a501_op3", op3_dFront_out, 0);
                check("a501_db", dBack_out, 1);
                fdone = 1'b1;
            end
            step(0, 0, '0, 100, 0);
        end
        check("a501_seen", fdone, 1);

        // stall held: FIFO fills, requests stop
        for (int i = 0; i < 10; i++) step(1, 0, '0, 100, 0);
        check("stall_req_off", imem_req, 0);
        check("stall_full", inst_valid, 1);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 100, 0);

        // redirect while waiting, ack delayed
        n = 0;
        while (!(m_busy && !m_discard) && n < 20) begin step(0, 0, '0, 0, 0); n++; end
        check("redir_in_wait", imem_req, 1);
        step(0, 1, 16'h0040, 0, 0);
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 100, 0);
        seen_req = 1'b0;
        seen_val = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_busy && !seen_req) begin check("redir_addr", imem_addr, 16'h0040); seen_req = 1'b1; end
            if (mq.size() > 0 && !seen_val) begin check("redir_pc", inst_pc, 16'h0040); seen_val = 1'b1; end
            step(0, 0, '0, 100, 0);
        end
        check("redir_seen", {seen_req, seen_val}, 2'b11);

        // redirect coinciding with ack and pop
        n = 0;
        while (!(mq.size() > 0 && m_busy && !m_discard) && n < 30) begin
            step(1, 0, '0, (mq.size() == 0) ? 100 : 0, 0);
            n++;
        end
        check("flush_setup", inst_valid & imem_req, 1);
        step(0, 1, 16'h1234, 100, 0);
        check("flush_empty", inst_valid, 0);
        seen_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mq.size() > 0 && !seen_val) begin check("flush_resume", inst_pc, 16'h1234); seen_val = 1'b1; end
            step(0, 0, '0, 100, 0);
        end

        // asynchronous reset in the middle of a request
        n = 0;
        while (!(m_busy && !m_discard) && n < 20) begin step(0, 0, '0, 0, 0); n++; end
        #2 reset = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_addr", imem_addr, RESET_PC);
        check("arst_valid", inst_valid, 0);
        check("arst_pc", inst_pc, 0);
        check("arst_fields", {op1_out, Rs_Ra_op2_out, Rd_Rb_cond_out, op3_dFront_out, dBack_out}, 0);
        check("arst_halted", halted, 0);
        model_reset();
        imem_ack = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 0, '0, 100, 0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(99) < 30, $urandom_range(99) < 5, 16'($urandom),
                 50, $urandom_range(1));
        end

        // halt encoding as ordinary traffic
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, '0, 100, 2);
        step(0, 1, 16'h0100, 100, 2);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 100, 0);
        compare_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the instruction register.
- Keeps the program counter and issues one-at-a-time requests to instruction memory over a req/ack handshake.
- Buffers returned 16-bit words in a small FIFO.
- Presents the head word pre-split into the five instruction-register fields.
- Handles stall from downstream and redirect (branch flush) from the execute stage.

Parameters:
- DEPTH, 2, prefetch FIFO entries (power of 2, at least 2).
- ADDR_W, 16, instruction address width.
- RESET_PC, 0, fetch address after reset.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-low reset.
- stall, in, 1, downstream not accepting; head is held.
- redirect, in, 1, single-cycle flush plus PC load.
- redirect_pc, in, ADDR_W, new fetch address.
- imem_req, out, 1, memory request.
- imem_addr, out, ADDR_W, request address.
- imem_ack, in, 1, data valid this cycle.
- imem_rdata, in, 16, instruction word.
- inst_valid, out, 1, head entry present.
- inst_pc, out, ADDR_W, address of head word.
- op1_out, out, 2, head[15:14].
- Rs_Ra_op2_out, out, 3, head[13:11].
- Rd_Rb_cond_out, out, 3, head[10:8].
- op3_dFront_out, out, 4, head[7:4].
- dBack_out, out, 4, head[3:0].
- halted, out, 1, halt reached (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-low):
  - fetch_pc = RESET_PC; FIFO empty; FSM in IDLE.
  - imem_req = 0, imem_addr = RESET_PC.
  - inst_valid = 0, all field outputs = 0, inst_pc = 0, halted = 0.
  - Reset asserted mid-request abandons the request; a late ack after reset release is ignored only if it arrives while in IDLE.
- FSM states: IDLE, WAIT, DROP.
  - IDLE: if (count + 0) < DEPTH and no redirect, register imem_req = 1 and imem_addr = fetch_pc, then go to WAIT.
  - WAIT: hold imem_req and imem_addr stable until imem_ack.
    - On ack, push {fetch_pc, imem_rdata}, set fetch_pc += 1 (wraps modulo 2^ADDR_W), set imem_req = 0, go to IDLE.
    - The earliest next request is the cycle after return to IDLE, i.e. at most one request per 2 cycles.
  - DROP: entered when redirect arrives while in WAIT. Keep imem_req high until ack, discard the data, go to IDLE.
- Outputs: fields and inst_pc are combinational from the FIFO head when inst_valid = 1, and 0 when empty.
- Pop occurs when inst_valid & !stall. The consumer captures on the same edge.
- A push and a pop in the same cycle are both performed; count is unchanged.
- Push when full cannot occur, because a request is issued only when the FIFO has room.
- Redirect has priority over everything in its cycle:
  - FIFO cleared and the same-cycle pop ignored.
  - A same-cycle ack in WAIT is discarded, fetch_pc = redirect_pc, and the FSM goes to IDLE.
  - Without a same-cycle ack in WAIT, the FSM goes to DROP.
  - In IDLE or DROP, the FSM stays (or holds DROP) with fetch_pc = redirect_pc.
  - inst_valid = 0 the cycle after redirect.
- Redirect latency: inst_valid for the target word no earlier than 3 cycles after redirect, with ack on the first request cycle.
- stall held indefinitely: the FIFO fills to DEPTH, then imem_req stays 0.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- With it defined:
  - When a head word with op1 = 2'b11 and op3_dFront = 4'b1111 is popped, the unit enters HALTED.
  - In HALTED: FIFO cleared, no further requests (an outstanding one is completed and dropped), inst_valid = 0, halted = 1.
  - Only reset exits HALTED; redirect is ignored while halted.
- Without it: halted is constant 0 and that encoding passes through as an ordinary word.

Decomposition:
- Shared package holds:
  - field slice positions (OP1_MSB/LSB etc.).
  - ADDR_W default.
  - fetch FSM state enum {IDLE, WAIT, DROP}.
  - HLT encoding constants.
- One natural sub-module: fetch_fifo (synchronous DEPTH-entry FIFO of {pc, word}) with push, pop and clear, where clear has priority.

Test Plan:
- Reset then ack every request after 1 cycle with rdata = addr ^ 16'hA500, stall = 0:
  - sequential words observed with inst_pc 0, 1, 2, 3.
  - fields match the bit slices, e.g. 0xA501 gives op1 = 2, Rs_Ra_op2 = 4, Rd_Rb_cond = 5, op3_dFront = 0, dBack = 1.
- stall = 1 for 10 cycles:
  - exactly DEPTH pushes, then imem_req = 0.
  - head stays inst_pc = 0 until stall drops.
  - no word lost or duplicated.
- redirect to 0x0040 while in WAIT, with ack delayed 3 cycles:
  - the stale word is dropped.
  - the next inst_valid shows inst_pc = 0x0040.
  - imem_addr of the next request = 0x0040.
- redirect in the same cycle as imem_ack and a pop:
  - FIFO empty next cycle.
  - the acked word is never presented.
  - fetch resumes at redirect_pc.
- reset asserted mid-WAIT: all outputs zero immediately (asynchronous); fetch restarts at RESET_PC after release.
- With FETCH_HALT_DETECT_EN, word 0xC0F0 popped:
  - halted = 1 next cycle; imem_req stays 0.
  - a redirect has no effect.
